mips_memory: RTL and testbench

Word-addressed unified memory that sits directly downstream of the multicycle mips core. It serves the core's instruction fetch port and its data (load/store) port. It also holds the core in a stalled state while a streaming loader fills program memory after reset. Reads are registered with 1-cycle latency. Address range checks and alignment checks raise sticky error flags.

---
 rtl/mips_mem_pkg.sv | 22 ++
 rtl/mips_mem_array.sv | 57 +++++
 rtl/mips_memory.sv | 162 ++++++++++++++++
 tb/tb_mips_memory.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the mips unified memory: load/run state
// encoding, the value returned for bad reads, and the address range check.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    LOAD_WAIT = 2'd0,
    LOADING   = 2'd1,
    RUN       = 2'd2
  } mem_state_e;

  localparam logic [31:0] DEADDR_DATA = 32'h0000_0000;

  // The limit is carried at 33 bits so a window ending at 4 GiB does not wrap.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] limit);
    return (addr[1:0] == 2'b00) &&
           ({1'b0, addr} >= {1'b0, base}) &&
           ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Word storage with one write port and two registered read ports.
// Reads in the same cycle as a write to the same word return the old word.
module mips_mem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          a_en_i,
  input  logic          a_clr_i,
  input  logic [AW-1:0] a_addr_i,
  output logic [31:0]   a_data_o,
  input  logic          b_en_i,
  input  logic          b_clr_i,
  input  logic [AW-1:0] b_addr_i,
  output logic [31:0]   b_data_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] a_q;
  logic [31:0] b_q;

  // Contents are deliberately not reset so a reload after reset keeps old words.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Clear wins over enable; neither set means the port holds its last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= DEADDR_DATA;
      b_q <= DEADDR_DATA;
    end else begin
      if (a_clr_i) begin
        a_q <= DEADDR_DATA;
      end else if (a_en_i) begin
        a_q <= mem_q[a_addr_i];
      end
      if (b_clr_i) begin
        b_q <= DEADDR_DATA;
      end else if (b_en_i) begin
        b_q <= mem_q[b_addr_i];
      end
    end
  end

  assign a_data_o = a_q;
  assign b_data_o = b_q;

endmodule

// File: rtl/mips_memory.sv
// Unified instruction/data memory for the multicycle mips core, with a
// streaming program loader that holds the core in reset until loading ends.
module mips_memory
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          LOAD_ENABLE = 1'b1,
  localparam int         AW          = $clog2(DEPTH_WORDS),
  localparam int         CW          = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instr_addr_i,
  output logic [31:0]   instr_data_o,
  input  logic          data_rd_wr_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic [31:0]   data_rdata_o,
  input  logic          ld_start_i,
  input  logic          ld_valid_i,
  input  logic [31:0]   ld_data_i,
  input  logic          ld_last_i,
  output logic          ld_ready_o,
  output logic          core_hold_o,
  output logic [CW-1:0] ld_count_o,
  output logic          instr_err_o,
  output logic          data_err_o,
  output logic          load_ovf_o,
  output mem_state_e    state_o
);

  // Loader handshake: a word transfers on a clock edge where ld_valid_i and
  // ld_ready_o are both high; ld_ready_o never depends on ld_valid_i.

  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  mem_state_e    state_q;
  logic          core_hold_q;
  logic          ld_ready_q;
  logic [CW-1:0] ld_count_q;
  logic          instr_err_q;
  logic          data_err_q;
  logic          load_ovf_q;

  logic          run;
  logic          i_ok;
  logic          d_ok;
  logic [AW-1:0] i_idx;
  logic [AW-1:0] d_idx;
  logic [AW-1:0] ptr;
  logic          ptr_at_end;
  logic          ld_accept;
  logic          core_wr;

  logic          we_d;
  logic [AW-1:0] waddr_d;
  logic [31:0]   wdata_d;
  logic          a_en_d;
  logic          a_clr_d;
  logic          b_en_d;
  logic          b_clr_d;

  assign run   = (state_q == RUN);
  assign i_ok  = addr_in_range(instr_addr_i, BASE_ADDR, LIMIT);
  assign d_ok  = addr_in_range(data_addr_i, BASE_ADDR, LIMIT);
  assign i_idx = AW'((instr_addr_i - BASE_ADDR) >> 2);
  assign d_idx = AW'((data_addr_i - BASE_ADDR) >> 2);

  // While loading, the word count below DEPTH_WORDS doubles as the write pointer.
  assign ptr        = ld_count_q[AW-1:0];
  assign ptr_at_end = (ptr == AW'(DEPTH_WORDS - 1));
  assign ld_accept  = (state_q == LOADING) && ld_ready_q && ld_valid_i;
  assign core_wr    = run && !data_rd_wr_i && d_ok;

  always_comb begin
    we_d    = ld_accept || core_wr;
    waddr_d = ld_accept ? ptr : d_idx;
    wdata_d = ld_accept ? ld_data_i : data_wdata_i;
    a_en_d  = run && i_ok;
    a_clr_d = !run || !i_ok;
    b_en_d  = run && data_rd_wr_i && d_ok;
    b_clr_d = !run || (data_rd_wr_i && !d_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD_ENABLE ? LOAD_WAIT : RUN;
      core_hold_q <= LOAD_ENABLE;
      ld_ready_q  <= 1'b0;
      ld_count_q  <= '0;
      instr_err_q <= 1'b0;
      data_err_q  <= 1'b0;
      load_ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD_WAIT: begin
          if (ld_start_i) begin
            state_q    <= LOADING;
            ld_ready_q <= 1'b1;
            ld_count_q <= '0;
          end
        end
        LOADING: begin
          if (ld_accept) begin
            ld_count_q <= ld_count_q + CW'(1);
            if (ld_last_i || ptr_at_end) begin
              state_q     <= RUN;
              ld_ready_q  <= 1'b0;
              core_hold_q <= 1'b0;
            end
            // Filling the last word without an end marker means the image is too big.
            if (!ld_last_i && ptr_at_end) begin
              load_ovf_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!i_ok) begin
            instr_err_q <= 1'b1;
          end
          if (!d_ok) begin
            data_err_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= RUN;
          core_hold_q <= 1'b0;
          ld_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  mips_mem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .we_i     (we_d),
    .waddr_i  (waddr_d),
    .wdata_i  (wdata_d),
    .a_en_i   (a_en_d),
    .a_clr_i  (a_clr_d),
    .a_addr_i (i_idx),
    .a_data_o (instr_data_o),
    .b_en_i   (b_en_d),
    .b_clr_i  (b_clr_d),
    .b_addr_i (d_idx),
    .b_data_o (data_rdata_o)
  );

  assign ld_ready_o  = ld_ready_q;
  assign core_hold_o = core_hold_q;
  assign ld_count_o  = ld_count_q;
  assign instr_err_o = instr_err_q;
  assign data_err_o  = data_err_q;
  assign load_ovf_o  = load_ovf_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mips_memory.sv
// Bench for mips_memory: three instances (large loader, tiny loader, no loader)
// checked every cycle against a behavioural model, plus literal spot checks.
module tb_mips_memory;
  import mips_mem_pkg::*;

  localparam int N = 3;
  localparam int DEP0 = 64;
  localparam int DEP1 = 4;
  localparam int DEP2 = 16;
  localparam logic [31:0] BASE0 = 32'h0040_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0000;
  localparam logic [31:0] BASE2 = 32'h0000_1000;

  int          m_depth [N] = '{DEP0, DEP1, DEP2};
  logic [31:0] m_base  [N] = '{BASE0, BASE1, BASE2};
  bit          m_le    [N] = '{1'b1, 1'b1, 1'b0};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [N];
  logic [31:0] instr_addr [N];
  logic        data_rd_wr [N];
  logic [31:0] data_addr  [N];
  logic [31:0] data_wdata [N];
  logic        ld_start   [N];
  logic        ld_valid   [N];
  logic [31:0] ld_data    [N];
  logic        ld_last    [N];

  logic [31:0] instr_data [N];
  logic [31:0] data_rdata [N];
  logic        ld_ready   [N];
  logic        core_hold  [N];
  logic        instr_err  [N];
  logic        data_err   [N];
  logic        load_ovf   [N];
  mem_state_e  st         [N];
  logic [6:0]  cnt0;
  logic [2:0]  cnt1;
  logic [4:0]  cnt2;
  logic [31:0] cnt_a      [N];

  always_comb begin
    cnt_a[0] = 32'(cnt0);
    cnt_a[1] = 32'(cnt1);
    cnt_a[2] = 32'(cnt2);
  end

  mips_memory #(.DEPTH_WORDS(DEP0), .BASE_ADDR(BASE0), .LOAD_ENABLE(1'b1)) u_main (
    .clk(clk), .reset(rst[0]), .instr_addr_i(instr_addr[0]), .instr_data_o(instr_data[0]),
    .data_rd_wr_i(data_rd_wr[0]), .data_addr_i(data_addr[0]), .data_wdata_i(data_wdata[0]),
    .data_rdata_o(data_rdata[0]), .ld_start_i(ld_start[0]), .ld_valid_i(ld_valid[0]),
    .ld_data_i(ld_data[0]), .ld_last_i(ld_last[0]), .ld_ready_o(ld_ready[0]),
    .core_hold_o(core_hold[0]), .ld_count_o(cnt0), .instr_err_o(instr_err[0]),
    .data_err_o(data_err[0]), .load_ovf_o(load_ovf[0]), .state_o(st[0]));

  mips_memory #(.DEPTH_WORDS(DEP1), .BASE_ADDR(BASE1), .LOAD_ENABLE(1'b1)) u_small (
    .clk(clk), .reset(rst[1]), .instr_addr_i(instr_addr[1]), .instr_data_o(instr_data[1]),
    .data_rd_wr_i(data_rd_wr[1]), .data_addr_i(data_addr[1]), .data_wdata_i(data_wdata[1]),
    .data_rdata_o(data_rdata[1]), .ld_start_i(ld_start[1]), .ld_valid_i(ld_valid[1]),
    .ld_data_i(ld_data[1]), .ld_last_i(ld_last[1]), .ld_ready_o(ld_ready[1]),
    .core_hold_o(core_hold[1]), .ld_count_o(cnt1), .instr_err_o(instr_err[1]),
    .data_err_o(data_err[1]), .load_ovf_o(load_ovf[1]), .state_o(st[1]));

  mips_memory #(.DEPTH_WORDS(DEP2), .BASE_ADDR(BASE2), .LOAD_ENABLE(1'b0)) u_noload (
    .clk(clk), .reset(rst[2]), .instr_addr_i(instr_addr[2]), .instr_data_o(instr_data[2]),
    .data_rd_wr_i(data_rd_wr[2]), .data_addr_i(data_addr[2]), .data_wdata_i(data_wdata[2]),
    .data_rdata_o(data_rdata[2]), .ld_start_i(ld_start[2]), .ld_valid_i(ld_valid[2]),
    .ld_data_i(ld_data[2]), .ld_last_i(ld_last[2]), .ld_ready_o(ld_ready[2]),
    .core_hold_o(core_hold[2]), .ld_count_o(cnt2), .instr_err_o(instr_err[2]),
    .data_err_o(data_err[2]), .load_ovf_o(load_ovf[2]), .state_o(st[2]));

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s got %h expected %h", k, nm, act, exp);
    end
  endtask

  // behavioural model: phase 0 = waiting for loader, 1 = loading, 2 = running
  logic [31:0] mmem   [N][64];
  bit          mknown [N][64];
  int          mph    [N];
  int          mcnt   [N];
  bit          m_init [N];
  logic [31:0] e_instr [N];
  logic [31:0] e_rdata [N];
  bit          e_ik [N];
  bit          e_dk [N];
  bit          e_ierr [N];
  bit          e_derr [N];
  bit          e_ovf  [N];

  function automatic bit a_ok(input int k, input logic [31:0] a);
    longint lo = longint'(m_base[k]);
    longint hi = lo + 4 * m_depth[k];
    return (a[1:0] == 2'b00) && (longint'(a) >= lo) && (longint'(a) < hi);
  endfunction

  function automatic int a_idx(input int k, input logic [31:0] a);
    return int'((a - m_base[k]) >> 2);
  endfunction

  task automatic model_step(input int k);
    bit iv, dv;
    int ii, di;
    if (rst[k] === 1'b1) begin
      m_init[k] = 1; mph[k] = m_le[k] ? 0 : 2; mcnt[k] = 0;
      e_instr[k] = 0; e_rdata[k] = 0; e_ik[k] = 1; e_dk[k] = 1;
      e_ierr[k] = 0; e_derr[k] = 0; e_ovf[k] = 0;
    end else if (!m_init[k]) begin
      // nothing known before the first reset
    end else if (mph[k] == 2) begin
      iv = a_ok(k, instr_addr[k]);
      dv = a_ok(k, data_addr[k]);
      ii = iv ? a_idx(k, instr_addr[k]) : 0;
      di = dv ? a_idx(k, data_addr[k]) : 0;
      e_instr[k] = iv ? mmem[k][ii] : 32'h0;
      e_ik[k] = iv ? mknown[k][ii] : 1'b1;
      if (!iv) e_ierr[k] = 1;
      if (!dv) e_derr[k] = 1;
      if (data_rd_wr[k]) begin
        e_rdata[k] = dv ? mmem[k][di] : 32'h0;
        e_dk[k] = dv ? mknown[k][di] : 1'b1;
      end else if (dv) begin
        mmem[k][di] = data_wdata[k];
        mknown[k][di] = 1;
      end
    end else begin
      e_instr[k] = 0; e_rdata[k] = 0; e_ik[k] = 1; e_dk[k] = 1;
      if (mph[k] == 0) begin
        if (ld_start[k]) begin mph[k] = 1; mcnt[k] = 0; end
      end else if (ld_valid[k]) begin
        mmem[k][mcnt[k]] = ld_data[k];
        mknown[k][mcnt[k]] = 1;
        mcnt[k]++;
        if (ld_last[k]) mph[k] = 2;
        else if (mcnt[k] == m_depth[k]) begin mph[k] = 2; e_ovf[k] = 1; end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) model_step(k);
  end

  // compare process: outputs are registered, so sample on the falling edge
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (m_init[k]) begin
        chk(k, "core_hold", 32'(core_hold[k]), 32'(mph[k] != 2));
        chk(k, "ld_ready", 32'(ld_ready[k]), 32'(mph[k] == 1));
        chk(k, "ld_count", cnt_a[k], 32'(mcnt[k]));
        chk(k, "state", 32'(st[k]),
            32'(mph[k] == 0 ? LOAD_WAIT : (mph[k] == 1 ? LOADING : RUN)));
        chk(k, "instr_err", 32'(instr_err[k]), 32'(e_ierr[k]));
        chk(k, "data_err", 32'(data_err[k]), 32'(e_derr[k]));
        chk(k, "load_ovf", 32'(load_ovf[k]), 32'(e_ovf[k]));
        if (e_ik[k]) chk(k, "instr_data", instr_data[k], e_instr[k]);
        if (e_dk[k]) chk(k, "data_rdata", data_rdata[k], e_rdata[k]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs(input int k);
    instr_addr[k] = m_base[k]; data_rd_wr[k] = 1'b1; data_addr[k] = m_base[k];
    data_wdata[k] = 32'h0; ld_start[k] = 1'b0; ld_valid[k] = 1'b0;
    ld_data[k] = 32'h0; ld_last[k] = 1'b0;
  endtask

  task automatic load_word(input int k, input logic [31:0] w, input logic last);
    ld_valid[k] = 1'b1; ld_data[k] = w; ld_last[k] = last;
    tick();
    ld_valid[k] = 1'b0; ld_last[k] = 1'b0;
  endtask

  task automatic pulse_reset(input int k);
    rst[k] = 1'b1;
    tick();
    rst[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1;
      idle_inputs(k);
    end
    tick(); tick();
    chk(0, "rst_core_hold", 32'(core_hold[0]), 32'd1);
    chk(0, "rst_ld_ready", 32'(ld_ready[0]), 32'd0);
    chk(0, "rst_instr_data", instr_data[0], 32'h0);
    chk(2, "rst_noload_hold", 32'(core_hold[2]), 32'd0);
    for (int k = 0; k < N; k++) rst[k] = 1'b0;
    tick();

    // program load of three words, then fetch the third
    ld_start[0] = 1'b1; tick(); ld_start[0] = 1'b0;
    chk(0, "loading_ready", 32'(ld_ready[0]), 32'd1);
    load_word(0, 32'hA000_0000, 1'b0);
    load_word(0, 32'hA000_0001, 1'b0);
    load_word(0, 32'hA000_0002, 1'b1);
    for (int i = 0; i < 8 && core_hold[0] !== 1'b0; i++) tick();
    chk(0, "load_done_hold", 32'(core_hold[0]), 32'd0);
    chk(0, "load_count3", cnt_a[0], 32'd3);
    instr_addr[0] = BASE0 + 32'd8; tick();
    chk(0, "fetch_word2", instr_data[0], 32'hA000_0002);
    chk(0, "idle_read_word0", data_rdata[0], 32'hA000_0000);

    // store, colliding fetch, read back
    data_rd_wr[0] = 1'b0; data_addr[0] = BASE0 + 32'd4; data_wdata[0] = 32'h1234_5678;
    instr_addr[0] = BASE0 + 32'd4; tick();
    chk(0, "collide_fetch_old", instr_data[0], 32'hA000_0001);
    chk(0, "rdata_held_on_write", data_rdata[0], 32'hA000_0000);
    data_rd_wr[0] = 1'b1; tick();
    chk(0, "read_after_write", data_rdata[0], 32'h1234_5678);
    chk(0, "fetch_after_write", instr_data[0], 32'h1234_5678);

    // misaligned fetch, out-of-range store
    instr_addr[0] = BASE0 + 32'd2; tick();
    chk(0, "bad_fetch_err", 32'(instr_err[0]), 32'd1);
    chk(0, "bad_fetch_data", instr_data[0], 32'h0);
    instr_addr[0] = BASE0;
    data_rd_wr[0] = 1'b0; data_addr[0] = BASE0 + 32'(4 * DEP0); data_wdata[0] = 32'hDEAD_BEEF;
    tick();
    data_rd_wr[0] = 1'b1; data_addr[0] = BASE0; tick();
    chk(0, "bad_store_err", 32'(data_err[0]), 32'd1);
    chk(0, "bad_store_dropped", data_rdata[0], 32'hA000_0000);
    repeat (3) tick();
    chk(0, "err_sticky", 32'(instr_err[0] & data_err[0]), 32'd1);

    // reset in the middle of a load, then reload one word
    pulse_reset(0);
    chk(0, "reset_clears_err", 32'(instr_err[0] | data_err[0]), 32'd0);
    ld_start[0] = 1'b1; tick(); ld_start[0] = 1'b0;
    load_word(0, 32'hB000_0000, 1'b0);
    load_word(0, 32'hB000_0001, 1'b0);
    pulse_reset(0);
    chk(0, "midload_reset_count", cnt_a[0], 32'd0);
    chk(0, "midload_reset_hold", 32'(core_hold[0]), 32'd1);
    ld_start[0] = 1'b1; tick(); ld_start[0] = 1'b0;
    load_word(0, 32'hC000_0000, 1'b1);
    chk(0, "reload_count1", cnt_a[0], 32'd1);
    chk(0, "reload_run", 32'(core_hold[0]), 32'd0);
    instr_addr[0] = BASE0 + 32'd4; tick();
    chk(0, "contents_kept", instr_data[0], 32'hB000_0001);
    instr_addr[0] = BASE0; tick();
    chk(0, "reloaded_word0", instr_data[0], 32'hC000_0000);

    // overflow on the four-word instance
    ld_start[1] = 1'b1; tick(); ld_start[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk(1, "ovf_ready_seen", 32'(ld_ready[1]), (i < 4) ? 32'd1 : 32'd0);
      load_word(1, 32'hD000_0000 + 32'(i), 1'b0);
    end
    chk(1, "ovf_count4", cnt_a[1], 32'd4);
    chk(1, "ovf_flag", 32'(load_ovf[1]), 32'd1);
    chk(1, "ovf_run", 32'(core_hold[1]), 32'd0);
    instr_addr[1] = 32'd12; tick();
    chk(1, "ovf_last_word", instr_data[1], 32'hD000_0003);

    // no-loader instance ignores ld_start and serves data at once
    ld_start[2] = 1'b1; tick(); ld_start[2] = 1'b0; tick();
    chk(2, "noload_ready", 32'(ld_ready[2]), 32'd0);
    chk(2, "noload_hold", 32'(core_hold[2]), 32'd0);
    data_rd_wr[2] = 1'b0; data_addr[2] = BASE2 + 32'd8; data_wdata[2] = 32'hCAFE_F00D; tick();
    data_rd_wr[2] = 1'b1; tick();
    chk(2, "noload_rw", data_rdata[2], 32'hCAFE_F00D);
    instr_addr[2] = BASE2 + 32'd8; tick();
    chk(2, "noload_fetch", instr_data[2], 32'hCAFE_F00D);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
